// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: width helpers and parameter-legality check shared by the
// synchronous FIFO and its storage sub-module.
package sync_fifo_pkg;

    // Pointer width: enough bits to address DEPTH words.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: one extra bit so the full value DEPTH is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit params_legal(input int d_wd, input int depth,
                                        input int af_thr, input int ae_thr);
        bit pow2;
        pow2 = (depth >= 4) && ((depth & (depth - 1)) == 0);
        return (d_wd >= 1) && pow2 &&
               (af_thr >= 1) && (af_thr <= depth - 1) &&
               (ae_thr >= 1) && (ae_thr <= depth - 1) &&
               (ae_thr < af_thr);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: D_WD x DEPTH register array, one write port and one
// asynchronous read port. Contents are deliberately not reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int D_WD  = 16,
    parameter int DEPTH = 16,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [D_WD-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [D_WD-1:0] o_rdata
);

    logic [D_WD-1:0] mem [DEPTH];

    // Store the incoming word on an enabled write.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count, occupancy flags and
// sticky overflow/underflow flags. Storage lives in sync_fifo_mem.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through output;
// otherwise o_data is a register loaded on each accepted read.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int D_WD   = 16,
    parameter int DEPTH  = 16,
    parameter int AF_THR = DEPTH - 2,
    parameter int AE_THR = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [D_WD-1:0]          i_data,
    input  logic                     i_write,
    input  logic                     i_read,
    input  logic                     i_clr_err,
    output logic [D_WD-1:0]          o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_afull,
    output logic                     o_aempty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_ovf,
    output logic                     o_udf
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THR);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THR);

    if (!params_legal(D_WD, DEPTH, AF_THR, AE_THR)) begin : g_bad_params
        $error("sync_fifo: illegal parameter combination");
    end

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt_nxt;
    logic [D_WD-1:0] head_word;
    logic            wr_acc;
    logic            rd_acc;

    assign wr_acc = i_write && !o_full;
    assign rd_acc = i_read && !o_empty;

    sync_fifo_mem #(
        .D_WD  (D_WD),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_acc && !i_rst),
        .i_waddr (wr_ptr),
        .i_wdata (i_data),
        .i_raddr (rd_ptr),
        .o_rdata (head_word)
    );

    // Next occupancy: a simultaneous read and write cancel out.
    always_comb begin
        cnt_nxt = o_count;
        if (wr_acc && !rd_acc) begin
            cnt_nxt = o_count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_nxt = o_count - CW'(1);
        end
    end

    // Pointers, count, occupancy flags and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_count  <= '0;
            o_full   <= 1'b0;
            o_empty  <= 1'b1;
            o_afull  <= 1'b0;
            o_aempty <= 1'b1;
            o_ovf    <= 1'b0;
            o_udf    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            o_count  <= cnt_nxt;
            o_full   <= (cnt_nxt == FULL_CNT);
            o_empty  <= (cnt_nxt == '0);
            o_afull  <= (cnt_nxt >= AF_CNT);
            o_aempty <= (cnt_nxt <= AE_CNT);
            if (i_write && o_full) begin
                o_ovf <= 1'b1;
            end else if (i_clr_err) begin
                o_ovf <= 1'b0;
            end
            if (i_read && o_empty) begin
                o_udf <= 1'b1;
            end else if (i_clr_err) begin
                o_udf <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign o_data = o_empty ? '0 : head_word;
`else
    // Registered output: capture the head word on each accepted read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= '0;
        end else if (rd_acc) begin
            o_data <= head_word;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed stimulus for sync_fifo, with a
// queue-based reference model and a decoupled output monitor.
module tb_sync_fifo;

    localparam int D_WD   = 16;
    localparam int DEPTH  = 8;
    localparam int AF_THR = 6;
    localparam int AE_THR = 2;

    logic              clk;
    logic              rst;
    logic [D_WD-1:0]   data_in;
    logic              wr;
    logic              rd;
    logic              clr;
    logic [D_WD-1:0]   data_out;
    logic              full;
    logic              empty;
    logic              afull;
    logic              aempty;
    logic [3:0]        count;
    logic              ovf;
    logic              udf;

    int tests_run = 0;
    int tests_failed = 0;

    logic [D_WD-1:0] sb_q[$];
    int              model_cnt = 0;
    bit              model_ovf = 0;
    bit              model_udf = 0;
    bit              model_rst = 0;
    bit              armed = 0;
    bit              pend_rd = 0;
    bit              pend_rst = 0;
    logic [D_WD-1:0] last_out = '0;

    sync_fifo #(
        .D_WD   (D_WD),
        .DEPTH  (DEPTH),
        .AF_THR (AF_THR),
        .AE_THR (AE_THR)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data_in),
        .i_write   (wr),
        .i_read    (rd),
        .i_clr_err (clr),
        .o_data    (data_out),
        .o_full    (full),
        .o_empty   (empty),
        .o_afull   (afull),
        .o_aempty  (aempty),
        .o_count   (count),
        .o_ovf     (ovf),
        .o_udf     (udf)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge and advance the
    // reference model to the state expected after the next rising edge.
    task automatic applyStimulus(input bit w, input bit r,
                                 input logic [D_WD-1:0] d,
                                 input bit c, input bit rs);
        bit is_full;
        bit is_empty;
        bit w_ok;
        bit r_ok;
        @(negedge clk);
        #1;
        wr = w;
        rd = r;
        data_in = d;
        clr = c;
        rst = rs;
        armed = 1'b1;
        model_rst = rs;
        if (rs) begin
            model_cnt = 0;
            model_ovf = 0;
            model_udf = 0;
            sb_q.delete();
        end else begin
            is_full  = (model_cnt == DEPTH);
            is_empty = (model_cnt == 0);
            w_ok = w && !is_full;
            r_ok = r && !is_empty;
            if (w_ok) sb_q.push_back(d);
            model_cnt = model_cnt + int'(w_ok) - int'(r_ok);
            if (w && is_full) model_ovf = 1;
            else if (c) model_ovf = 0;
            if (r && is_empty) model_udf = 1;
            else if (c) model_udf = 0;
        end
    endtask

    // Note which rising edges accepted a read or applied reset.
    always @(posedge clk) begin
        pend_rd  = rd && !empty && !rst;
        pend_rst = rst;
    end

    // Monitor: compare the DUT against the model after every rising edge.
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("count",  32'(count),  32'(model_cnt));
            checkOutput("full",   32'(full),   32'(model_cnt == DEPTH));
            checkOutput("empty",  32'(empty),  32'(model_cnt == 0));
            checkOutput("afull",  32'(afull),  32'(model_cnt >= AF_THR));
            checkOutput("aempty", 32'(aempty), 32'(model_cnt <= AE_THR));
            checkOutput("ovf",    32'(ovf),    32'(model_ovf));
            checkOutput("udf",    32'(udf),    32'(model_udf));
            if (pend_rst) begin
                checkOutput("data_rst", 32'(data_out), 32'h0);
                last_out = '0;
            end
`ifdef SYNC_FIFO_FWFT_EN
            if (pend_rd && sb_q.size() > 0) void'(sb_q.pop_front());
            if (!empty) begin
                if (sb_q.size() > 0) begin
                    checkOutput("data_head", 32'(data_out), 32'(sb_q[0]));
                end else begin
                    checkOutput("data_extra", 32'(empty), 32'h1);
                end
            end else if (!pend_rst) begin
                checkOutput("data_empty", 32'(data_out), 32'h0);
            end
`else
            if (pend_rd) begin
                if (sb_q.size() > 0) begin
                    last_out = sb_q.pop_front();
                    checkOutput("data_pop", 32'(data_out), 32'(last_out));
                end else begin
                    checkOutput("data_underrun", 32'(sb_q.size()), 32'h1);
                end
            end else if (!pend_rst) begin
                checkOutput("data_hold", 32'(data_out), 32'(last_out));
            end
`endif
            if (model_rst) model_rst = 0;
        end
    end

    initial begin
        logic [D_WD-1:0] pat;
        int written;
        wr = 0; rd = 0; data_in = '0; clr = 0; rst = 1;

        applyStimulus(0, 0, '0, 0, 1);
        applyStimulus(0, 0, '0, 0, 1);

        // Fill 0x0001..0x0008, then one rejected write.
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1, 0, D_WD'(i), 0, 0);
        applyStimulus(1, 0, 16'h00FF, 0, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, '0, 0, 0);

        // Underflow, clear, and set-beats-clear.
        applyStimulus(0, 1, '0, 0, 0);
        applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(0, 1, '0, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);

        // Wrap: 20 incrementing writes, reads once four words are held.
        pat = 16'h0100;
        written = 0;
        while (written < 20) begin
            applyStimulus(1, model_cnt >= 4, pat, 0, 0);
            pat++;
            written++;
        end
        while (model_cnt > 0) applyStimulus(0, 1, '0, 0, 0);

        // Reset with five words stored, then reuse.
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, D_WD'(16'h0A00 + i), 0, 0);
        applyStimulus(1, 1, 16'h1234, 0, 1);
        applyStimulus(1, 0, 16'hBEEF, 0, 0);
        applyStimulus(0, 0, '0, 0, 0);
        applyStimulus(0, 1, '0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0);

        // Randomized traffic with occasional clears and rare resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                          D_WD'($urandom), $urandom_range(0, 15) == 0,
                          $urandom_range(0, 79) == 0);
        end
        while (model_cnt > 0) applyStimulus(0, 1, '0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter D_WD, default 16, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, word capacity; power of 2, >=4.
REQ-003 SHALL have parameter AF_THR, default DEPTH-2, almost-full threshold in words (1..DEPTH-1).
REQ-004 SHALL have parameter AE_THR, default 2, almost-empty threshold in words (1..DEPTH-1), less than AF_THR.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_data, input, D_WD, write data.
REQ-008 SHALL have port i_write, input, 1, write request.
REQ-009 SHALL have port i_read, input, 1, read request.
REQ-010 SHALL have port i_clr_err, input, 1, clears the sticky error flags.
REQ-011 SHALL have port o_data, output, D_WD, read data.
REQ-012 SHALL have ports o_full, o_empty, o_afull and o_aempty, each output, 1, occupancy flags.
REQ-013 SHALL have port o_count, output, $clog2(DEPTH)+1, words stored (0..DEPTH).
REQ-014 SHALL have ports o_ovf and o_udf, each output, 1, sticky overflow and underflow flags.

Function
REQ-015 SHALL accept a write iff i_write && !o_full; the word is stored at the write pointer, and the pointer increments, wrapping at DEPTH.
REQ-016 SHALL accept a read iff i_read && !o_empty; the read pointer increments, wrapping at DEPTH.
REQ-017 SHALL, on simultaneous accepted read and write, leave o_count unchanged; when full, the read is accepted, the write is rejected and o_ovf is set.
REQ-018 SHALL register o_count, updating it in the cycle after each accept: +1 write only, -1 read only.
REQ-019 SHALL register the flags from the next count:
- o_full = (count==DEPTH)
- o_empty = (count==0)
- o_afull = (count>=AF_THR)
- o_aempty = (count<=AE_THR)
REQ-020 SHALL have 1-cycle write-to-visibility latency: a write accepted in cycle N into an empty FIFO deasserts o_empty in cycle N+1.
REQ-021 SHALL set o_ovf on any rejected write (i_write && o_full).
REQ-022 SHALL set o_udf on any rejected read (i_read && o_empty).
REQ-023 SHALL keep o_ovf and o_udf set until i_clr_err or reset; a set in the same cycle as i_clr_err takes priority over the clear.
REQ-024 SHALL ignore rejected requests with respect to pointers, memory, count and o_data.
REQ-025 SHALL preserve first-in first-out data order across any number of pointer wraps.

Reset
REQ-026 SHALL, while i_rst is high at a clock edge, clear pointers, o_count, o_data, o_ovf, o_udf, o_full and o_afull to 0, and set o_empty and o_aempty to 1.
REQ-027 SHALL, when reset is asserted mid-operation, discard all stored words; requests in the reset cycle are ignored, and memory contents are not reset.

Configuration
REQ-028 SHALL support macro SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through): o_data combinationally shows the head word whenever !o_empty and 0 when empty; an accepted read advances to the next word in the following cycle.
- Undefined (standard): o_data is registered; it loads the head word in the cycle after an accepted read and holds otherwise.

Structure
REQ-029 SHALL place the pointer-width and count-width helper constants and a parameter-legality check function in package sync_fifo_pkg.
REQ-030 SHALL isolate storage in sub-module sync_fifo_mem: a D_WD x DEPTH register array with 1 write port and 1 asynchronous read port; all control and flags stay in sync_fifo.

Verification (DEPTH=8, AF_THR=6, AE_THR=2, D_WD=16)
REQ-031 SHALL verify fill: write 0x0001..0x0008 on consecutive cycles -> o_count 1..8, o_aempty drops at count 3, o_afull rises at count 6, o_full at count 8, o_ovf stays 0.
REQ-032 SHALL verify overflow and order: with the FIFO full, write 0x00FF -> o_ovf=1 and count stays 8; then read 8 -> data 0x0001..0x0008 in order, o_empty=1.
REQ-033 SHALL verify underflow and clear: read while empty -> o_udf=1; pulse i_clr_err -> o_udf=0 next cycle; read while empty together with i_clr_err -> o_udf remains 1.
REQ-034 SHALL verify wrap: interleave 20 writes of an incrementing pattern from 0x0100 with reads at count 4 -> output sequence 0x0100..0x0113 unbroken; simultaneous read/write holds the count.
REQ-035 SHALL verify reset mid-operation: assert i_rst with count=5 -> next cycle o_count=0, o_empty=1, o_data=0; a following write of 0xBEEF is read back as 0xBEEF.
REQ-036 SHALL verify the mode: with SYNC_FIFO_FWFT_EN, o_data=0x0001 one cycle after the first write with no read; without it, 0x0001 appears one cycle after the read is accepted.
